// File: rtl/bus_async_tgt_if.sv
// Command/response handshake between the async bridge's master-side port and the register target.
// The master drives commands and stall; the slave returns the response strobe and data.
interface bus_async_tgt_if #(
    parameter int AW = 12
) ();
    logic            cpvalid;
    logic [AW+36:0]  cpdata;
    logic            hold;
    logic            dpready;
    logic [32:0]     dpdata;

    modport master (
        output cpvalid,
        output cpdata,
        output hold,
        input  dpready,
        input  dpdata
    );

    modport slave (
        input  cpvalid,
        input  cpdata,
        input  hold,
        output dpready,
        output dpdata
    );
endinterface

// File: rtl/bus_async_tgt.sv
// Register-bank target for the master side of the async bus bridge: one command at a time,
// fixed wait states stretched by hold, then a single registered response strobe.
module bus_async_tgt #(
    parameter int          AW      = 12,
    parameter int          DW      = 32,
    parameter int          NREG    = 8,
    parameter int          WAITCYC = 2,
    parameter logic [31:0] IDVAL   = 32'hB0C1_0001
) (
    input  logic               clk,
    input  logic               resetn,
    bus_async_tgt_if.slave     bus,
    output logic [NREG*32-1:0] regs
);

    localparam int            CW       = 1 + 4 + AW + DW;
    localparam int            IW       = AW - 2;
    localparam logic [IW-1:0] NREG_L   = IW'(NREG);
    localparam logic [3:0]    WAIT_L   = 4'(WAITCYC);
    localparam logic          HAS_WAIT = (WAITCYC > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [3:0]                cnt_r;
    logic [CW-1:0]             cmd_r;
    logic [NREG-1:1][DW-1:0]   regs_r;
    logic                      dpready_r;
    logic [DW:0]               dpdata_r;

    logic [CW-1:0]             sel_s;
    logic                      sel_we_s;
    logic [3:0]                sel_be_s;
    logic [AW-1:0]             sel_addr_s;
    logic [DW-1:0]             sel_wdata_s;
    logic                      sel_err_s;
    logic [DW-1:0]             rsp_rdata_s;
    logic [DW:0]               rsp_s;
    logic                      dpready_nxt_s;
    logic                      wr_en_s;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [3:0]    be);
        logic [DW-1:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[k*8 +: 8] = new_v[k*8 +: 8];
            else       res[k*8 +: 8] = old_v[k*8 +: 8];
        end
        return res;
    endfunction

    // Register 0 is the read-only ID, so a write aimed at it is reported as an error.
    function automatic logic decode_err(input logic we, input logic [AW-1:0] addr);
        return (addr[AW-1:2] >= NREG_L) || (addr[1:0] != 2'b00) ||
               (we && (addr[AW-1:2] == {IW{1'b0}}));
    endfunction

    function automatic logic [DW-1:0] read_mux(input logic [NREG-1:1][DW-1:0] bank,
                                               input logic [IW-1:0]           ix);
        logic [DW-1:0] res;
        res = IDVAL;
        for (int i = 1; i < NREG; i++) begin
            if (ix == IW'(i)) res = bank[i];
            else              res = res;
        end
        return res;
    endfunction

    // In IDLE the live bus is decoded so a zero-wait command can respond on the next edge.
    always_comb begin
        if (state_r == ST_IDLE) sel_s = bus.cpdata;
        else                    sel_s = cmd_r;
        sel_we_s    = sel_s[CW-1];
        sel_be_s    = sel_s[CW-2 -: 4];
        sel_addr_s  = sel_s[DW +: AW];
        sel_wdata_s = sel_s[DW-1:0];
        sel_err_s   = decode_err(sel_we_s, sel_addr_s);
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Next-state logic; cpvalid is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cpvalid) begin
                    if (HAS_WAIT || bus.hold) state_nxt_s = ST_WAIT;
                    else                      state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.hold && (cnt_r <= 4'd1)) state_nxt_s = ST_RESP;
                else                              state_nxt_s = ST_WAIT;
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: response word, strobe request and write enable.
    always_comb begin
        dpready_nxt_s = (state_nxt_s == ST_RESP);
        if (sel_we_s || sel_err_s) rsp_rdata_s = {DW{1'b0}};
        else                       rsp_rdata_s = read_mux(regs_r, sel_addr_s[AW-1:2]);
        rsp_s   = {sel_err_s, rsp_rdata_s};
        wr_en_s = (state_r == ST_RESP) && sel_we_s && !sel_err_s;
    end

    // Wait-state counter: loaded at capture, frozen while hold is high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= 4'd0;
        end else if ((state_r == ST_IDLE) && bus.cpvalid) begin
            cnt_r <= WAIT_L;
        end else if ((state_r == ST_WAIT) && !bus.hold && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Command capture register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  cmd_r <= {CW{1'b0}};
        else if ((state_r == ST_IDLE) && bus.cpvalid) cmd_r <= bus.cpdata;
    end

    // Registered response; dpdata keeps its value between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dpready_r <= 1'b0;
            dpdata_r  <= {(DW+1){1'b0}};
        end else begin
            dpready_r <= dpready_nxt_s;
            if (dpready_nxt_s) dpdata_r <= rsp_s;
        end
    end

    // Register bank write, committed at the end of the response cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_r <= {((NREG-1)*DW){1'b0}};
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en_s && (sel_addr_s[AW-1:2] == IW'(i)))
                    regs_r[i] <= lane_merge(regs_r[i], sel_wdata_s, sel_be_s);
            end
        end
    end

    assign bus.dpready = dpready_r;
    assign bus.dpdata  = dpdata_r;
    assign regs        = {regs_r, IDVAL};

endmodule

// File: tb/tb_bus_async_tgt.sv
// Bench for bus_async_tgt: two instances (2 and 0 wait states) share stimulus and are checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_bus_async_tgt;

    localparam int          AW    = 12;
    localparam int          NREG  = 8;
    localparam int          WIN   = 12;
    localparam logic [31:0] IDVAL = 32'hB0C1_0001;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    bus_async_tgt_if #(.AW(AW)) bif0 ();
    bus_async_tgt_if #(.AW(AW)) bif1 ();
    logic [NREG*32-1:0] regs0;
    logic [NREG*32-1:0] regs1;

    assign bif1.cpvalid = bif0.cpvalid;
    assign bif1.cpdata  = bif0.cpdata;
    assign bif1.hold    = bif0.hold;

    bus_async_tgt #(.AW(AW), .DW(32), .NREG(NREG), .WAITCYC(2), .IDVAL(IDVAL)) u_dut0 (
        .clk(clk), .resetn(resetn), .bus(bif0), .regs(regs0));
    bus_async_tgt #(.AW(AW), .DW(32), .NREG(NREG), .WAITCYC(0), .IDVAL(IDVAL)) u_dut1 (
        .clk(clk), .resetn(resetn), .bus(bif1), .regs(regs1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_resp [2];
    logic        m_busy [2];
    int          m_need [2];
    logic [48:0] m_cmd  [2];
    logic [32:0] e_dpd  [2];
    logic [31:0] mregs  [2][NREG];

    function automatic int wc(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic logic m_err(input logic [48:0] c);
        int a;
        int idx;
        a   = int'(c[43:32]);
        idx = a / 4;
        return (idx >= NREG) || (a % 4 != 0) || (c[48] && idx == 0);
    endfunction

    function automatic logic [32:0] m_rsp(input int u, input logic [48:0] c);
        int idx;
        idx = int'(c[43:32]) / 4;
        if (m_err(c)) return {1'b1, 32'h0};
        if (c[48])    return {1'b0, 32'h0};
        if (idx == 0) return {1'b0, IDVAL};
        return {1'b0, mregs[u][idx]};
    endfunction

    function automatic logic [NREG*32-1:0] m_flat(input int u);
        logic [NREG*32-1:0] f;
        for (int k = 0; k < NREG; k++) f[k*32 +: 32] = mregs[u][k];
        return f;
    endfunction

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!resetn) begin
                m_resp[u] = 1'b0;
                m_busy[u] = 1'b0;
                m_need[u] = 0;
                e_dpd[u]  = 33'h0;
                for (int k = 0; k < NREG; k++) mregs[u][k] = (k == 0) ? IDVAL : 32'h0;
            end else if (m_resp[u]) begin
                m_resp[u] = 1'b0;
                m_busy[u] = 1'b0;
                if (m_cmd[u][48] && !m_err(m_cmd[u])) begin
                    for (int k = 0; k < 4; k++)
                        if (m_cmd[u][44+k])
                            mregs[u][int'(m_cmd[u][43:32]) / 4][k*8 +: 8] = m_cmd[u][k*8 +: 8];
                end
            end else if (!m_busy[u]) begin
                if (bif0.cpvalid) begin
                    m_cmd[u]  = bif0.cpdata;
                    m_busy[u] = 1'b1;
                    m_need[u] = (wc(u) == 0 && bif0.hold) ? 1 : wc(u);
                    if (m_need[u] == 0) begin
                        e_dpd[u]  = m_rsp(u, m_cmd[u]);
                        m_resp[u] = 1'b1;
                    end
                end
            end else begin
                if (!bif0.hold) m_need[u]--;
                if (m_need[u] <= 0) begin
                    e_dpd[u]  = m_rsp(u, m_cmd[u]);
                    m_resp[u] = 1'b1;
                end
            end
        end
        check("d0_dpready", {255'h0, bif0.dpready}, {255'h0, m_resp[0]});
        check("d0_dpdata",  {223'h0, bif0.dpdata},  {223'h0, e_dpd[0]});
        check("d0_regs",    regs0, m_flat(0));
        check("d1_dpready", {255'h0, bif1.dpready}, {255'h0, m_resp[1]});
        check("d1_dpdata",  {223'h0, bif1.dpdata},  {223'h0, e_dpd[1]});
        check("d1_regs",    regs1, m_flat(1));
    end

    // ---------------- directed stimulus ----------------
    int          lat0, lat1, n0;
    logic [32:0] d0;

    task automatic run_cmd(input logic we, input logic [3:0] be, input logic [11:0] addr,
                           input logic [31:0] wd, input int vcyc, input int hs, input int hl,
                           input int rst_at);
        lat0 = -1; lat1 = -1; n0 = 0; d0 = 33'h0;
        for (int j = 0; j < WIN; j++) begin
            bif0.cpvalid = (j < vcyc);
            bif0.cpdata  = {we, be, addr, wd};
            bif0.hold    = (j >= hs) && (j < hs + hl);
            if (j == rst_at)          resetn = 1'b0;
            else if (j == rst_at + 1) resetn = 1'b1;
            @(negedge clk);
            if (bif0.dpready) begin
                n0++;
                d0 = bif0.dpdata;
                if (lat0 < 0) lat0 = j + 1;
            end
            if (bif1.dpready && lat1 < 0) lat1 = j + 1;
            #1;
        end
        bif0.cpvalid = 1'b0;
        bif0.hold    = 1'b0;
    endtask

    logic [NREG*32-1:0] snap;

    initial begin
        bif0.cpvalid = 1'b0;
        bif0.cpdata  = '0;
        bif0.hold    = 1'b0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dpready", {255'h0, bif0.dpready}, 256'h0);
        check("rst_dpdata",  {223'h0, bif0.dpdata},  256'h0);
        check("rst_reg0",    {224'h0, regs0[31:0]},  {224'h0, 32'hB0C1_0001});
        check("rst_reg1",    {224'h0, regs0[63:32]}, 256'h0);
        #1 resetn = 1'b1;
        @(negedge clk); #1;

        run_cmd(1'b1, 4'hF, 12'h004, 32'h1234_5678, 1, 99, 0, -5);
        check("wr1_lat",   lat0, 256'd3);
        check("wr1_count", n0, 256'd1);
        check("wr1_rsp",   {223'h0, d0}, 256'h0);
        check("wr1_reg1",  {224'h0, regs0[63:32]}, {224'h0, 32'h1234_5678});
        check("wc0_lat",   lat1, 256'd1);

        run_cmd(1'b0, 4'h0, 12'h004, 32'h0, 4, 99, 0, -5);
        check("rd1_lat",   lat0, 256'd3);
        check("rd1_count", n0, 256'd1);
        check("rd1_rsp",   {223'h0, d0}, {223'h0, 33'h0_1234_5678});

        run_cmd(1'b1, 4'b0010, 12'h008, 32'hAABB_CCDD, 1, 99, 0, -5);
        check("be_rsp",  {223'h0, d0}, 256'h0);
        check("be_reg2", {224'h0, regs0[95:64]}, {224'h0, 32'h0000_CC00});

        run_cmd(1'b0, 4'h0, 12'h000, 32'h0, 1, 99, 0, -5);
        check("id_rsp", {223'h0, d0}, {223'h0, 33'h0_B0C1_0001});

        run_cmd(1'b0, 4'h0, 12'h040, 32'h0, 1, 99, 0, -5);
        check("oob_rsp", {223'h0, d0}, {223'h0, 33'h1_0000_0000});

        snap = regs0;
        run_cmd(1'b1, 4'hF, 12'h006, 32'hFFFF_FFFF, 1, 99, 0, -5);
        check("mis_rsp",  {223'h0, d0}, {223'h0, 33'h1_0000_0000});
        check("mis_regs", regs0, snap);

        run_cmd(1'b1, 4'hF, 12'h000, 32'hDEAD_BEEF, 1, 99, 0, -5);
        check("id_wr_rsp",  {223'h0, d0}, {223'h0, 33'h1_0000_0000});
        check("id_wr_reg0", {224'h0, regs0[31:0]}, {224'h0, 32'hB0C1_0001});

        run_cmd(1'b0, 4'h0, 12'h004, 32'h0, 1, 1, 5, -5);
        check("hold_lat", lat0, 256'd8);
        check("hold_rsp", {223'h0, d0}, {223'h0, 33'h0_1234_5678});

        run_cmd(1'b1, 4'hF, 12'h00C, 32'hCAFE_F00D, 1, 99, 0, 2);
        check("rst_mid_count", n0, 256'd0);
        check("rst_mid_reg3",  {224'h0, regs0[127:96]}, 256'h0);

        run_cmd(1'b1, 4'hF, 12'h00C, 32'hCAFE_F00D, 1, 99, 0, -5);
        check("post_rst_lat",  lat0, 256'd3);
        check("post_rst_reg3", {224'h0, regs0[127:96]}, {224'h0, 32'hCAFE_F00D});

        // Randomised traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 3000; c++) begin
            logic [11:0] a;
            a = 12'(($urandom_range(0, NREG + 1) * 4) +
                    (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
            bif0.cpvalid = ($urandom_range(0, 2) != 0);
            bif0.cpdata  = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, 32'($urandom)};
            bif0.hold    = ($urandom_range(0, 4) == 0);
            resetn       = ($urandom_range(0, 199) != 0);
            @(negedge clk); #1;
        end
        resetn       = 1'b1;
        bif0.cpvalid = 1'b0;
        bif0.hold    = 1'b0;
        repeat (WIN) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
